lbist_pattern_gen: RTL
======================

# lbist_pattern_gen

Upstream stage of the core's logic BIST. On `start`, an LFSR produces two 12-bit random operands. The block writes a fixed 17-word RV32I test program embedding those operands into instruction memory, then releases the core for a fixed run window. It then drives the check window that feeds the output response analyzer (random operands, `inst_end`, data-memory read address) and latches the analyzer's pass/fail verdict.

## Interface
Parameters:
- `SEED`, 24'hACE1B5: LFSR reset value; must be nonzero.
- `IMEM_BASE`, 32'h0000_0000: byte address of the first program word.
- `DMEM_BASE`, 12'h000: byte offset of the first result word; `DMEM_BASE+28` must fit in 12 bits.
- `RUN_CYCLES`, 64: cycles the core runs; range 17..65535.

Ports:
- `clk`  in  1  clock, rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request; only honoured in IDLE or DONE.
- `P_F`  in  1  verdict from the response analyzer.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  32  write byte address.
- `imem_wdata`  out  32  instruction word.
- `core_rst`  out  1  holds the core in reset when high.
- `random_value_1`, `random_value_2`  out  12  operands to the analyzer; stable from end of GEN until the next `start`.
- `inst_end`  out  1  check-window strobe to the analyzer.
- `dmem_raddr`  out  32  data-memory read address during CHECK; the read is asynchronous.
- `busy`  out  1  high in GEN/WRITE/RUN/CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  latched verdict; valid while `done`.

## Operation
- States: IDLE → GEN → WRITE → RUN → CHECK → DONE. `start` in DONE returns to GEN.
- Reset values (all state asynchronous): state IDLE, lfsr=`SEED`, `core_rst`=1, all other outputs 0.
- LFSR: 24-bit Fibonacci, taps 24,23,22,17; shifts left with feedback into bit 0. Shifts only in GEN, once per cycle, for 24 cycles. Never reloaded except by `Rst`, so consecutive runs get new operands.
- Leaving GEN: `random_value_1`=lfsr[23:12], `random_value_2`=lfsr[11:0], both registered.
- WRITE: word i (0..16) goes to `imem_addr`=`IMEM_BASE`+4i. With r1/r2 the operands and off_k=`DMEM_BASE`+4(k-1), the words are:
  - 0: addi x1,x0,r1
  - 1: addi x2,x0,r2
  - 2: add x3,x1,x2
  - 3: sub x4,x1,x2
  - 4: and x5,x1,x2
  - 5: or x6,x1,x2
  - 6: slli x7,x1,1
  - 7: srli x8,x2,1
  - 8..15: sw xk,off_k(x0) for k=1..8
  - 16: jal x0,0 (32'h0000006F)
- Encoding is standard RV32I. The 12-bit immediates are placed raw, so the core sign-extends them to match the analyzer's model.
- RUN: `core_rst`=0 for `RUN_CYCLES` cycles, then back to 1. The core freezes in reset for CHECK.
- CHECK: 9 cycles, `inst_end`=1 throughout.
  - Cycle k=0..7: `dmem_raddr`=`DMEM_BASE`+4k.
  - Cycle 8: `dmem_raddr` holds `DMEM_BASE`+28. `P_F` is sampled into `pass` at the end of this cycle. This is the only cycle the analyzer's capture count equals 8.
  - `inst_end` drops on entering DONE.
- DONE: `done`=1 and `pass` held until the next `start` or `Rst`. `pass` clears on entering GEN.
- `start` while `busy` is ignored; `start` held high in DONE restarts exactly once per entry to DONE.
- `Rst` mid-run: immediate return to IDLE, `core_rst`=1, `imem_we`=0, `inst_end`=0. The LFSR returns to `SEED`.

## Timing
- `start` sampled at edge T; GEN occupies T+1..T+24.
- WRITE occupies 17 cycles with `imem_we`=1 each cycle: word 0 in cycle T+25, word 16 in T+41.
- RUN occupies `RUN_CYCLES` cycles, then CHECK occupies 9 cycles.
- `done` rises 24+17+`RUN_CYCLES`+9 cycles after the `start` edge: 114 with defaults.
- All outputs are registered, with no combinational path from `start` or `P_F` to any output.
- `imem_we` and `inst_end` are never high simultaneously. `core_rst` is 0 only in RUN.

## Test plan
- Reset, then pulse `start` → `busy` next cycle; 17 consecutive `imem_we` pulses at addresses 0x00..0x40; `done` at cycle 114 after `start`.
- Force r1=12'h800, r2=12'h7FF via `SEED` chosen by the reference model:
  - word 0 = 32'h80000093.
  - word 2 = 32'h002081B3.
  - word 8 = 32'h00102023 (`DMEM_BASE`=0).
  - word 16 = 32'h0000006F.
- Analyzer `P_F` model driven high only in CHECK cycle 8 → `pass`=1. `P_F` high in cycle 7 only → `pass`=0. During CHECK, `inst_end` is high exactly 9 cycles and `dmem_raddr` steps 0,4,…,28,28.
- Two back-to-back runs → operands differ and match the bit-accurate LFSR model after 24 and 48 shifts.
- `Rst` asserted during WRITE and during CHECK:
  - Immediately: `imem_we`=0, `inst_end`=0, `core_rst`=1, state IDLE.
  - A following `start` reproduces the first-run operands.
- `start` pulsed during RUN → ignored; `RUN_CYCLES`=17 gives exactly 17 cycles of `core_rst`=0.

Source files
------------

// File: rtl/lbist_pattern_gen.sv
// Logic-BIST stimulus sequencer: draws two LFSR operands, writes a 17-word RV32I
// test program into IMEM, runs the core, then drives the analyzer check window.
module lbist_pattern_gen #(
  parameter logic [23:0] SEED       = 24'hACE1B5,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_0000,
  parameter logic [11:0] DMEM_BASE  = 12'h000,
  parameter int          RUN_CYCLES = 64
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        start,
  input  logic        P_F,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic [11:0] random_value_1,
  output logic [11:0] random_value_2,
  output logic        inst_end,
  output logic [31:0] dmem_raddr,
  output logic        busy,
  output logic        done,
  output logic        pass
);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_WRITE, S_RUN, S_CHECK, S_DONE
  } state_t;

  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [6:0]  OP_REG   = 7'b0110011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [15:0] RUN_LAST = 16'(RUN_CYCLES - 1);

  // Program word idx; r1/r2 go in raw so the core sign-extends them.
  function automatic logic [31:0] prog_word(input logic [4:0] idx,
                                            input logic [11:0] r1,
                                            input logic [11:0] r2);
    logic [11:0] off;
    logic [4:0]  rs2;
    off = DMEM_BASE + {7'd0, idx[2:0], 2'b00};
    rs2 = {2'b00, idx[2:0]} + 5'd1;
    case (idx)
      5'd0:    prog_word = {r1, 5'd0, 3'b000, 5'd1, OP_IMM};
      5'd1:    prog_word = {r2, 5'd0, 3'b000, 5'd2, OP_IMM};
      5'd2:    prog_word = {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, OP_REG};
      5'd3:    prog_word = {7'h20, 5'd2, 5'd1, 3'b000, 5'd4, OP_REG};
      5'd4:    prog_word = {7'h00, 5'd2, 5'd1, 3'b111, 5'd5, OP_REG};
      5'd5:    prog_word = {7'h00, 5'd2, 5'd1, 3'b110, 5'd6, OP_REG};
      5'd6:    prog_word = {7'h00, 5'd1, 5'd1, 3'b001, 5'd7, OP_IMM};
      5'd7:    prog_word = {7'h00, 5'd1, 5'd2, 3'b101, 5'd8, OP_IMM};
      5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15:
               prog_word = {off[11:5], rs2, 5'd0, 3'b010, off[4:0], OP_STORE};
      default: prog_word = 32'h0000_006F;
    endcase
  endfunction

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [23:0] lfsr, lfsr_n, shifted;
  logic [11:0] rv1_n, rv2_n;
  logic        pass_n;
  logic        imem_we_n, core_rst_n, inst_end_n, busy_n, done_n;
  logic [31:0] imem_addr_n, imem_wdata_n, dmem_raddr_n;
  logic [2:0]  rd_idx;

  assign shifted = {lfsr[22:0], lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16]};

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    lfsr_n  = lfsr;
    rv1_n   = random_value_1;
    rv2_n   = random_value_2;
    pass_n  = pass;
    case (state)
      S_IDLE, S_DONE: begin
        cnt_n = 16'd0;
        if (start) begin
          state_n = S_GEN;
          pass_n  = 1'b0;
        end
      end
      S_GEN: begin
        lfsr_n = shifted;
        if (cnt == 16'd23) begin
          state_n = S_WRITE;
          cnt_n   = 16'd0;
          rv1_n   = shifted[23:12];
          rv2_n   = shifted[11:0];
        end
      end
      S_WRITE: if (cnt == 16'd16) begin
        state_n = S_RUN;
        cnt_n   = 16'd0;
      end
      S_RUN: if (cnt == RUN_LAST) begin
        state_n = S_CHECK;
        cnt_n   = 16'd0;
      end
      S_CHECK: if (cnt == 16'd8) begin
        state_n = S_DONE;
        cnt_n   = 16'd0;
        pass_n  = P_F;
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are registered: decode them from the upcoming state.
    rd_idx       = (cnt_n[3:0] > 4'd7) ? 3'd7 : cnt_n[2:0];
    imem_we_n    = (state_n == S_WRITE);
    imem_addr_n  = imem_we_n ? IMEM_BASE + {25'd0, cnt_n[4:0], 2'b00} : 32'd0;
    imem_wdata_n = imem_we_n ? prog_word(cnt_n[4:0], rv1_n, rv2_n) : 32'd0;
    core_rst_n   = (state_n != S_RUN);
    inst_end_n   = (state_n == S_CHECK);
    dmem_raddr_n = inst_end_n ? {20'd0, DMEM_BASE + {7'd0, rd_idx, 2'b00}} : 32'd0;
    busy_n       = (state_n != S_IDLE) && (state_n != S_DONE);
    done_n       = (state_n == S_DONE);
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state          <= S_IDLE;
      cnt            <= 16'd0;
      lfsr           <= SEED;
      random_value_1 <= 12'd0;
      random_value_2 <= 12'd0;
      pass           <= 1'b0;
      imem_we        <= 1'b0;
      imem_addr      <= 32'd0;
      imem_wdata     <= 32'd0;
      core_rst       <= 1'b1;
      inst_end       <= 1'b0;
      dmem_raddr     <= 32'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      lfsr           <= lfsr_n;
      random_value_1 <= rv1_n;
      random_value_2 <= rv2_n;
      pass           <= pass_n;
      imem_we        <= imem_we_n;
      imem_addr      <= imem_addr_n;
      imem_wdata     <= imem_wdata_n;
      core_rst       <= core_rst_n;
      inst_end       <= inst_end_n;
      dmem_raddr     <= dmem_raddr_n;
      busy           <= busy_n;
      done           <= done_n;
    end
  end

endmodule
